// File: rtl/interrupt_injector_pkg.sv
// interrupt_injector_pkg: shared widths, idle encoding, FSM states and opcodes for the injector.
package interrupt_injector_pkg;
  localparam int INSN_WIDTH_DEF = 32;
  localparam logic [31:0] NOP_INSN_DEF = 32'h00000000;
  localparam logic [7:0] OPC_JUMP = 8'hA0;
  localparam logic [7:0] OPC_FRAME = 8'hB0;
  localparam logic [7:0] OPC_SCORE = 8'hC0;
  typedef enum logic [1:0] {IDLE, OFFER, HOLDOFF} state_t;
endpackage

// File: rtl/interrupt_fifo.sv
// interrupt_fifo: synchronous FIFO; a push into a full FIFO is ignored unless a pop frees the slot the same cycle.
module interrupt_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign count = count_q;
  assign dout = mem_q[rd_ptr_q];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/interrupt_injector.sv
// interrupt_injector: queues new interrupt words and injects them into CPU fetch at safe points.
// Optional INT_COALESCE_EN: drop repeats of the last pushed word until the next frame_tick.
module interrupt_injector
  import interrupt_injector_pkg::*;
#(
  parameter int INSN_WIDTH = INSN_WIDTH_DEF,
  parameter int DEPTH = 4,
  parameter logic [INSN_WIDTH-1:0] NOP_INSN = INSN_WIDTH'(NOP_INSN_DEF),
  parameter int HOLDOFF_CYCLES = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [INSN_WIDTH-1:0]      interrupt_instruction,
  input  logic                       frame_tick,
  input  logic                       cpu_fetch_ready,
  output logic                       inject_valid,
  output logic [INSN_WIDTH-1:0]      inject_instruction,
  output logic [$clog2(DEPTH):0]     pending_count,
  output logic                       overflow
);
  localparam int CW = HOLDOFF_CYCLES > 1 ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLDOFF_CYCLES > 0 ? HOLDOFF_CYCLES - 1 : 0);
  state_t state_q, state_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [INSN_WIDTH-1:0] prev_q, head;
  logic overflow_q, overflow_d;
  logic req, push, accept, full, empty;
  logic [$clog2(DEPTH):0] count;
  assign req = interrupt_instruction != NOP_INSN && interrupt_instruction != prev_q;
  assign accept = inject_valid && cpu_fetch_ready;
  assign overflow_d = overflow_q | (push && full && !accept);
`ifdef INT_COALESCE_EN
  logic [INSN_WIDTH-1:0] last_q, last_d;
  logic seen_q, seen_d, written;
  assign push = req && !(seen_q && !frame_tick && interrupt_instruction == last_q);
  assign written = push && (!full || accept);
  assign last_d = written ? interrupt_instruction : last_q;
  assign seen_d = written | (seen_q & !frame_tick);
  always_ff @(posedge clock) begin
    if (reset) begin
      last_q <= NOP_INSN;
      seen_q <= 1'b0;
    end else begin
      last_q <= last_d;
      seen_q <= seen_d;
    end
  end
`else
  logic frame_tick_unused;
  assign frame_tick_unused = frame_tick;
  assign push = req;
`endif
  interrupt_fifo #(.WIDTH(INSN_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock(clock), .reset(reset), .push(push), .pop(accept),
    .din(interrupt_instruction), .dout(head), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    case (state_q)
      IDLE: state_d = empty ? IDLE : OFFER;
      OFFER:
        if (accept) begin
          if (HOLDOFF_CYCLES > 0) begin
            state_d = HOLDOFF;
            hold_d = HOLD_INIT;
          end else begin
            state_d = (count > 1 || push) ? OFFER : IDLE;
          end
        end
      HOLDOFF:
        if (hold_q == '0) state_d = empty ? IDLE : OFFER;
        else hold_d = hold_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q <= '0;
      prev_q <= NOP_INSN;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      prev_q <= interrupt_instruction;
      overflow_q <= overflow_d;
    end
  end
  // head is a FIFO register that only moves on accept, so the offered word is stable
  assign inject_valid = state_q == OFFER;
  assign inject_instruction = inject_valid ? head : NOP_INSN;
  assign pending_count = count;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_interrupt_injector.sv
// tb_interrupt_injector: directed self-checking bench for interrupt_injector.
module tb_interrupt_injector;
  import interrupt_injector_pkg::*;
  localparam logic [31:0] NOP = 32'h00000000;
  localparam logic [31:0] WA = {OPC_JUMP, 24'h000001};
  localparam logic [31:0] WB = {OPC_FRAME, 24'h000002};
  localparam logic [31:0] WC = {OPC_SCORE, 24'h000003};
  localparam logic [31:0] WD = {OPC_JUMP, 24'h000004};
  localparam logic [31:0] WE = {OPC_FRAME, 24'h000005};
  logic clock = 1'b0;
  logic reset, frame_tick, cpu_fetch_ready;
  logic [31:0] interrupt_instruction;
  logic inject_valid, overflow;
  logic [31:0] inject_instruction;
  logic [2:0] pending_count;
  int tests_run = 0;
  int tests_failed = 0;
  interrupt_injector dut (
    .clock(clock), .reset(reset), .interrupt_instruction(interrupt_instruction),
    .frame_tick(frame_tick), .cpu_fetch_ready(cpu_fetch_ready),
    .inject_valid(inject_valid), .inject_instruction(inject_instruction),
    .pending_count(pending_count), .overflow(overflow)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    interrupt_instruction = NOP;
    cpu_fetch_ready = 1'b0;
    frame_tick = 1'b0;
    step();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    tests_run++; if (inject_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", inject_valid); end
    tests_run++; if (inject_instruction !== NOP) begin tests_failed++; $display("FAIL reset_insn got %h want %h", inject_instruction, NOP); end
    tests_run++; if (pending_count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", pending_count); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask
  task automatic test_single();
    int pulses = 0;
    int first = -1;
    logic [31:0] val = NOP;
    do_reset();
    cpu_fetch_ready = 1'b1;
    interrupt_instruction = WA;
    for (int i = 0; i < 12; i++) begin
      step();
      if (inject_valid) begin
        pulses++;
        if (first < 0) begin first = i; val = inject_instruction; end
      end
    end
    interrupt_instruction = NOP;
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL single_pulses got %0d want 1", pulses); end
    tests_run++; if (first !== 1) begin tests_failed++; $display("FAIL single_latency got edge %0d want edge 1 (0-based)", first); end
    tests_run++; if (val !== WA) begin tests_failed++; $display("FAIL single_value got %h want %h", val, WA); end
    tests_run++; if (pending_count !== 3'd0) begin tests_failed++; $display("FAIL single_count_end got %0d want 0", pending_count); end
  endtask
  task automatic test_overflow();
    logic [31:0] words [5] = '{WA, WB, WC, WD, WE};
    logic [31:0] got [$];
    int idx [$];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      interrupt_instruction = words[i];
      step();
    end
    interrupt_instruction = NOP;
    step();
    tests_run++; if (pending_count !== 3'd4) begin tests_failed++; $display("FAIL ovf_count got %0d want 4", pending_count); end
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %b want 1", overflow); end
    tests_run++; if (inject_instruction !== WA || inject_valid !== 1'b1) begin tests_failed++; $display("FAIL ovf_head got %b/%h want 1/%h", inject_valid, inject_instruction, WA); end
    cpu_fetch_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (inject_valid) begin got.push_back(inject_instruction); idx.push_back(i); end
      step();
    end
    tests_run++; if (got.size() !== 4) begin tests_failed++; $display("FAIL ovf_drain_n got %0d want 4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      tests_run++; if (got[k] !== words[k]) begin tests_failed++; $display("FAIL ovf_order[%0d] got %h want %h", k, got[k], words[k]); end
      if (k > 0) begin
        tests_run++; if (idx[k] - idx[k-1] !== 3) begin tests_failed++; $display("FAIL ovf_gap[%0d] got %0d want 3", k, idx[k] - idx[k-1]); end
      end
    end
    tests_run++; if (pending_count !== 3'd0 || overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_end got cnt %0d ovf %b want 0/1", pending_count, overflow); end
  endtask
  task automatic test_stall();
    do_reset();
    interrupt_instruction = WC;
    step();
    interrupt_instruction = NOP;
    step();
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (inject_valid !== 1'b1 || inject_instruction !== WC) begin tests_failed++; $display("FAIL stall_hold[%0d] got %b/%h want 1/%h", i, inject_valid, inject_instruction, WC); end
      step();
    end
    cpu_fetch_ready = 1'b1;
    step();
    tests_run++; if (inject_valid !== 1'b0 || pending_count !== 3'd0) begin tests_failed++; $display("FAIL stall_accept got %b/%0d want 0/0", inject_valid, pending_count); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] exp [4] = '{WB, WC, WD, WE};
    logic [31:0] got [$];
    do_reset();
    interrupt_instruction = WA; step();
    interrupt_instruction = WB; step();
    interrupt_instruction = WC; step();
    interrupt_instruction = WD; step();
    tests_run++; if (pending_count !== 3'd4) begin tests_failed++; $display("FAIL b2b_fill got %0d want 4", pending_count); end
    interrupt_instruction = WE;
    cpu_fetch_ready = 1'b1;
    step();
    tests_run++; if (pending_count !== 3'd4) begin tests_failed++; $display("FAIL b2b_count got %0d want 4", pending_count); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL b2b_overflow got %b want 0", overflow); end
    interrupt_instruction = NOP;
    for (int i = 0; i < 30; i++) begin
      if (inject_valid) got.push_back(inject_instruction);
      step();
    end
    tests_run++; if (got.size() !== 4) begin tests_failed++; $display("FAIL b2b_drain_n got %0d want 4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      tests_run++; if (got[k] !== exp[k]) begin tests_failed++; $display("FAIL b2b_order[%0d] got %h want %h", k, got[k], exp[k]); end
    end
  endtask
  task automatic test_reset_mid_offer();
    do_reset();
    do_reset();
    interrupt_instruction = WD;
    step();
    step();
    tests_run++; if (inject_valid !== 1'b1) begin tests_failed++; $display("FAIL midrst_pre got %b want 1", inject_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++; if (inject_valid !== 1'b0 || pending_count !== 3'd0 || overflow !== 1'b0) begin tests_failed++; $display("FAIL midrst_clear got %b/%0d/%b want 0/0/0", inject_valid, pending_count, overflow); end
    step();
    tests_run++; if (pending_count !== 3'd1) begin tests_failed++; $display("FAIL midrst_redetect got %0d want 1", pending_count); end
    step();
    tests_run++; if (inject_valid !== 1'b1 || inject_instruction !== WD) begin tests_failed++; $display("FAIL midrst_offer got %b/%h want 1/%h", inject_valid, inject_instruction, WD); end
    interrupt_instruction = NOP;
  endtask
`ifdef INT_COALESCE_EN
  task automatic test_coalesce();
    int pulses = 0;
    logic [31:0] seq [3] = '{WA, NOP, WA};
    do_reset();
    cpu_fetch_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      interrupt_instruction = i < 3 ? seq[i] : NOP;
      step();
      if (inject_valid) pulses++;
    end
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL coal_frame got %0d want 1", pulses); end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      interrupt_instruction = i == 0 ? WA : NOP;
      step();
      if (inject_valid) pulses++;
    end
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL coal_next_frame got %0d want 1", pulses); end
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL timeout run_time exceeded");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_stall();
    test_back_to_back();
    test_reset_mid_offer();
`ifdef INT_COALESCE_EN
    test_coalesce();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
